// File: rtl/isp8_spad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : isp8_spad_pkg
//  Purpose  : Shared definitions for the isp8 scratchpad controller. Holds the
//             FSM state encoding, a clog2 helper and the sizing expressions
//             for total depth, RAM index width and wait-counter width.
//  Revision : 1.0  initial release
// ============================================================================
package isp8_spad_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
    } spad_state_e;

    // Number of bits needed to index 'value' items (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int spad_total(input int depth, input int pages);
        return depth * pages;
    endfunction

    // Depth is at least 2, so the index is always at least one bit wide.
    function automatic int spad_idx_w(input int depth, input int pages);
        return clog2(depth * pages);
    endfunction

    // The wait counter must hold the largest legal WAIT_STATES value (15).
    localparam int SPAD_WAIT_MAX = 15;
    localparam int SPAD_WAIT_W   = 4;

    // Sizing of the default configuration (32 words x 4 pages).
    localparam int SPAD_TOTAL_DEF = spad_total(32, 4);
    localparam int SPAD_IDX_W_DEF = spad_idx_w(32, 4);

endpackage : isp8_spad_pkg
`default_nettype wire

// File: rtl/isp8_spad_ram.sv
`default_nettype none
// ============================================================================
//  Module   : isp8_spad_ram
//  Purpose  : Single-port RAM with synchronous read for the isp8 scratchpad.
//             Write has priority over read; contents are not reset.
//  Ports    : clk      - clock
//             we_i     - write enable
//             re_i     - read enable (read data appears after the edge)
//             addr_i   - word index
//             wdata_i  - write data
//             rdata_o  - registered read data, held until the next read
//  Revision : 1.0  initial release
// ============================================================================
module isp8_spad_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule : isp8_spad_ram
`default_nettype wire

// File: rtl/isp8_spad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : isp8_spad_ctrl
//  Purpose  : Scratchpad controller for the isp8 external memory bus. Zero
//             fills the RAM after reset, then serves level-held read/write
//             requests with programmable wait states and a one-cycle ready
//             pulse. Addresses >= SPAD_DEPTH*NUM_PAGES are misses: they never
//             touch the RAM, return MISS_DATA on reads and set spad_miss.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             ext_addr          - word address
//             ext_addr_cyc      - address cycle qualifier
//             ext_mem_rd/wr     - level requests, held until ready
//             ext_mem_dout      - write data from the core
//             ext_mem_din       - read data to the core
//             ext_mem_ready     - one-cycle completion pulse
//             spad_busy         - zero-fill in progress
//             spad_miss         - sticky out-of-range flag
//             par_flip          - (parity build) invert stored parity bit
//             spad_perr         - (parity build) sticky parity error flag
//  Options  : ISP8_SPAD_PARITY_EN - store even parity alongside each word
//  Revision : 1.0  initial release
// ============================================================================
module isp8_spad_ctrl
    import isp8_spad_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    SPAD_DEPTH  = 32,
    parameter int                    NUM_PAGES   = 4,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] MISS_DATA   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic                  ext_addr_cyc,
    input  logic                  ext_mem_rd,
    input  logic                  ext_mem_wr,
    input  logic [DATA_WIDTH-1:0] ext_mem_dout,
`ifdef ISP8_SPAD_PARITY_EN
    input  logic                  par_flip,
    output logic                  spad_perr,
`endif
    output logic [DATA_WIDTH-1:0] ext_mem_din,
    output logic                  ext_mem_ready,
    output logic                  spad_busy,
    output logic                  spad_miss
);

    localparam int TOTAL = spad_total(SPAD_DEPTH, NUM_PAGES);
    localparam int IDX_W = spad_idx_w(SPAD_DEPTH, NUM_PAGES);
`ifdef ISP8_SPAD_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    spad_state_e             state_q;
    logic [IDX_W-1:0]        fill_q;
    logic [SPAD_WAIT_W-1:0]  wcnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic                    hit_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    miss_q;
    logic [DATA_WIDTH-1:0]   din_q;
    // Set during the first DONE cycle of a read hit: the RAM output register
    // already holds the new word, so it is steered straight to ext_mem_din
    // and folded into din_q at the end of that cycle.
    logic                    rsel_q;
`ifdef ISP8_SPAD_PARITY_EN
    logic                    pflip_q;
    logic                    perr_q;
`endif

    logic                    w_req;
    logic                    w_hit;
    logic                    w_ram_we;
    logic                    w_ram_re;
    logic [IDX_W-1:0]        w_ram_addr;
    logic [RAM_W-1:0]        w_ram_wdata;
    logic [RAM_W-1:0]        w_ram_rdata;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_req = ext_addr_cyc & (ext_mem_rd | ext_mem_wr);
    // Zero-extend by one bit so a TOTAL equal to 2**ADDR_WIDTH still compares.
    assign w_hit = ({1'b0, ext_addr} < (ADDR_WIDTH + 1)'(TOTAL));

    // rst gates the write so an access aborted by reset never lands in RAM.
    assign w_ram_we   = ~rst & ((state_q == ST_INIT) |
                                ((state_q == ST_ACCESS) & hit_q & wr_q));
    assign w_ram_re   = (state_q == ST_ACCESS) & hit_q & ~wr_q;
    assign w_ram_addr = (state_q == ST_INIT) ? fill_q : idx_q;
    assign w_rd_word  = w_ram_rdata[DATA_WIDTH-1:0];

`ifdef ISP8_SPAD_PARITY_EN
    assign w_ram_wdata = (state_q == ST_INIT) ? '0 : {(^wdata_q) ^ pflip_q, wdata_q};
    assign spad_perr   = perr_q;
`else
    assign w_ram_wdata = (state_q == ST_INIT) ? '0 : wdata_q;
`endif

    isp8_spad_ram #(
        .WIDTH   (RAM_W),
        .DEPTH   (TOTAL),
        .AW      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .re_i    (w_ram_re),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    assign ext_mem_din   = rsel_q ? w_rd_word : din_q;
    assign ext_mem_ready = ready_q;
    assign spad_busy     = busy_q;
    assign spad_miss     = miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            fill_q  <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            miss_q  <= 1'b0;
            din_q   <= '0;
            rsel_q  <= 1'b0;
`ifdef ISP8_SPAD_PARITY_EN
            pflip_q <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            if (rsel_q) begin
                din_q  <= w_rd_word;
                rsel_q <= 1'b0;
`ifdef ISP8_SPAD_PARITY_EN
                // Even parity over data plus stored bit must be zero.
                if (^w_ram_rdata) begin
                    perr_q <= 1'b1;
                end
`endif
            end

            case (state_q)
                ST_INIT: begin
                    fill_q <= fill_q + 1'b1;
                    if (fill_q == IDX_W'(TOTAL - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_req) begin
                        idx_q   <= ext_addr[IDX_W-1:0];
                        wdata_q <= ext_mem_dout;
                        wr_q    <= ext_mem_wr;   // rd & wr together is a write
                        hit_q   <= w_hit;
                        wcnt_q  <= SPAD_WAIT_W'(WAIT_STATES);
`ifdef ISP8_SPAD_PARITY_EN
                        pflip_q <= par_flip;
`endif
                        state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q <= SPAD_WAIT_W'(1)) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                    if (!hit_q) begin
                        miss_q <= 1'b1;
                        if (!wr_q) begin
                            din_q <= MISS_DATA;
                        end
                    end else if (!wr_q) begin
                        rsel_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Wait for the core to drop its held request so it is
                    // not accepted a second time.
                    if (!ext_mem_rd && !ext_mem_wr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

endmodule : isp8_spad_ctrl
`default_nettype wire
